// File: rtl/bullet_if.sv
// rtl/bullet_if.sv - fire request, tank pose, wall contacts and bullet outputs of bullet_ctrl
interface bullet_if;
  logic       ShootBullet;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [7:0] sin;
  logic [7:0] cos;
  logic [1:0] hitWallX;
  logic [1:0] hitWallY;
  logic [9:0] Bullet0X;
  logic [9:0] Bullet0Y;
  logic [9:0] Bullet1X;
  logic [9:0] Bullet1Y;
  logic [1:0] BulletActive;
  logic [9:0] BulletS;

  modport master (
    output ShootBullet, TankX, TankY, sin, cos, hitWallX, hitWallY,
    input  Bullet0X, Bullet0Y, Bullet1X, Bullet1Y, BulletActive, BulletS
  );

  modport slave (
    input  ShootBullet, TankX, TankY, sin, cos, hitWallX, hitWallY,
    output Bullet0X, Bullet0Y, Bullet1X, Bullet1Y, BulletActive, BulletS
  );
endinterface

// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - two-slot bullet launcher and mover with fire cooldown and wall bounce
module bullet_ctrl #(
  parameter int BULLET_STEP = 8,
  parameter int LIFETIME    = 240,
  parameter int COOLDOWN    = 15
) (
  input  logic      frame_clk,
  input  logic      Reset,
  bullet_if.slave   bus
);

  localparam logic [0:0] S_FREE = 1'b0;
  localparam logic [0:0] S_FLY  = 1'b1;

  logic [0:0] r_state [2];
  logic [9:0] r_x     [2];
  logic [9:0] r_y     [2];
  logic [9:0] r_vx    [2];
  logic [9:0] r_vy    [2];
  logic [7:0] r_age   [2];
  logic [7:0] r_cool;
  logic       r_shoot_prev;

  logic        w_fire;
  logic        w_accept;
  logic        w_slot;
  logic [13:0] w_px;
  logic [13:0] w_py;
  logic [9:0]  w_sx;
  logic [9:0]  w_sy;
  logic [9:0]  w_lvx;
  logic [9:0]  w_lvy;

  logic [9:0]  w_vx     [2];
  logic [9:0]  w_vy     [2];
  logic [10:0] w_nx     [2];
  logic [10:0] w_ny     [2];
  logic        w_out    [2];
  logic        w_expire [2];

  assign w_fire   = bus.ShootBullet & ~r_shoot_prev;
  assign w_accept = w_fire && (r_cool == 8'd0) &&
                    ((r_state[0] == S_FREE) || (r_state[1] == S_FREE));
  assign w_slot   = (r_state[0] == S_FLY);

  assign w_px  = 14'(BULLET_STEP) * {7'd0, bus.cos[6:0]};
  assign w_py  = 14'(BULLET_STEP) * {7'd0, bus.sin[6:0]};
  assign w_sx  = 10'(w_px >> 7);
  assign w_sy  = 10'(w_py >> 7);
  // Screen Y grows downward, so a positive sine moves the bullet up.
  assign w_lvx = bus.cos[7] ? -w_sx : w_sx;
  assign w_lvy = bus.sin[7] ? w_sy  : -w_sy;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_vx[i]     = bus.hitWallX[i] ? -r_vx[i] : r_vx[i];
      w_vy[i]     = bus.hitWallY[i] ? -r_vy[i] : r_vy[i];
      w_nx[i]     = {1'b0, r_x[i]} + {w_vx[i][9], w_vx[i]};
      w_ny[i]     = {1'b0, r_y[i]} + {w_vy[i][9], w_vy[i]};
      w_out[i]    = w_nx[i][10] || (w_nx[i] > 11'd639) ||
                    w_ny[i][10] || (w_ny[i] > 11'd479);
      w_expire[i] = (r_age[i] == 8'(LIFETIME - 1));
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_shoot_prev <= 1'b0;
      r_cool       <= 8'd0;
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= S_FREE;
        r_x[i]     <= 10'd0;
        r_y[i]     <= 10'd0;
        r_vx[i]    <= 10'd0;
        r_vy[i]    <= 10'd0;
        r_age[i]   <= 8'd0;
      end
    end else begin
      r_shoot_prev <= bus.ShootBullet;
      if (w_accept) begin
        r_cool <= 8'(COOLDOWN);
      end else if (r_cool != 8'd0) begin
        r_cool <= r_cool - 8'd1;
      end
      for (int i = 0; i < 2; i++) begin
        if (r_state[i] == S_FLY) begin
          if (w_expire[i]) begin
            r_state[i] <= S_FREE;
          end else begin
            r_vx[i] <= w_vx[i];
            r_vy[i] <= w_vy[i];
            // Leaving the playfield frees the slot but keeps the last on-screen position.
            if (w_out[i]) begin
              r_state[i] <= S_FREE;
            end else begin
              r_x[i]   <= w_nx[i][9:0];
              r_y[i]   <= w_ny[i][9:0];
              r_age[i] <= r_age[i] + 8'd1;
            end
          end
        end else if (w_accept && (w_slot == 1'(i))) begin
          r_state[i] <= S_FLY;
          r_x[i]     <= bus.TankX;
          r_y[i]     <= bus.TankY;
          r_vx[i]    <= w_lvx;
          r_vy[i]    <= w_lvy;
          r_age[i]   <= 8'd0;
        end
      end
    end
  end

  assign bus.Bullet0X     = r_x[0];
  assign bus.Bullet0Y     = r_y[0];
  assign bus.Bullet1X     = r_x[1];
  assign bus.Bullet1Y     = r_y[1];
  assign bus.BulletActive = {r_state[1], r_state[0]};
  assign bus.BulletS      = 10'd2;

endmodule

// File: tb/tb_bullet_ctrl.sv
// tb/tb_bullet_ctrl.sv - directed and randomized checks of bullet_ctrl against a behavioural model
module tb_bullet_ctrl;
  localparam int STEP = 8;
  localparam int LIFE = 240;
  localparam int CD   = 15;

  logic frame_clk;
  logic Reset;
  bullet_if bus ();

  bullet_ctrl #(.BULLET_STEP(STEP), .LIFETIME(LIFE), .COOLDOWN(CD)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  int m_act [2];
  int m_x   [2];
  int m_y   [2];
  int m_vx  [2];
  int m_vy  [2];
  int m_age [2];
  int m_cool;
  int m_prev;

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
      m_vx[i] = 0; m_vy[i] = 0; m_age[i] = 0;
    end
    m_cool = 0;
    m_prev = 0;
  endtask

  // One frame of game rules, evaluated on the pre-edge state.
  task automatic model_step();
    int fire, accept, slot, sx, sy, nx, ny;
    int pre [2];
    pre[0] = m_act[0];
    pre[1] = m_act[1];
    fire   = (bus.ShootBullet && !m_prev) ? 1 : 0;
    m_prev = bus.ShootBullet ? 1 : 0;
    accept = (fire && m_cool == 0 && (!pre[0] || !pre[1])) ? 1 : 0;
    slot   = pre[0] ? 1 : 0;
    if (accept) m_cool = CD;
    else if (m_cool > 0) m_cool--;
    for (int i = 0; i < 2; i++) begin
      if (pre[i]) begin
        if (m_age[i] == LIFE - 1) begin
          m_act[i] = 0;
        end else begin
          if (bus.hitWallX[i]) m_vx[i] = -m_vx[i];
          if (bus.hitWallY[i]) m_vy[i] = -m_vy[i];
          nx = m_x[i] + m_vx[i];
          ny = m_y[i] + m_vy[i];
          if (nx < 0 || nx > 639 || ny < 0 || ny > 479) begin
            m_act[i] = 0;
          end else begin
            m_x[i] = nx;
            m_y[i] = ny;
            m_age[i]++;
          end
        end
      end else if (accept && slot == i) begin
        sx = (STEP * int'(bus.cos[6:0])) / 128;
        sy = (STEP * int'(bus.sin[6:0])) / 128;
        m_act[i] = 1;
        m_x[i]   = int'(bus.TankX);
        m_y[i]   = int'(bus.TankY);
        m_age[i] = 0;
        m_vx[i]  = bus.cos[7] ? -sx : sx;
        m_vy[i]  = bus.sin[7] ? sy : -sy;
      end
    end
  endtask

  task automatic compare_all();
    chk("active", int'(bus.BulletActive), m_act[1] * 2 + m_act[0]);
    chk("b0x", int'(bus.Bullet0X), m_x[0]);
    chk("b0y", int'(bus.Bullet0Y), m_y[0]);
    chk("b1x", int'(bus.Bullet1X), m_x[1]);
    chk("b1y", int'(bus.Bullet1Y), m_y[1]);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.ShootBullet = 1'b0;
    bus.hitWallX = 2'b00;
    bus.hitWallY = 2'b00;
    #2;
    model_reset();
    Reset = 1'b0;
  endtask

  task automatic fire_once();
    bus.ShootBullet = 1'b1;
    tick();
    bus.ShootBullet = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.ShootBullet = 1'b0;
    bus.TankX = 10'd0;
    bus.TankY = 10'd0;
    bus.sin = 8'h00;
    bus.cos = 8'h00;
    bus.hitWallX = 2'b00;
    bus.hitWallY = 2'b00;
    model_reset();
    @(posedge frame_clk);
    #1;
    chk("rst_active", int'(bus.BulletActive), 0);
    chk("rst_b0x", int'(bus.Bullet0X), 0);
    chk("rst_b1y", int'(bus.Bullet1Y), 0);
    chk("bullet_size", int'(bus.BulletS), 2);
    Reset = 1'b0;

    // Straight right launch; ShootBullet already high on the first post-reset edge.
    bus.cos = 8'h7F; bus.sin = 8'h00; bus.TankX = 10'd300; bus.TankY = 10'd250;
    fire_once();
    chk("right_act0", int'(bus.BulletActive), 1);
    chk("right_x0", int'(bus.Bullet0X), 300);
    chk("right_y0", int'(bus.Bullet0Y), 250);
    tick();
    chk("right_x1", int'(bus.Bullet0X), 307);
    chk("right_y1", int'(bus.Bullet0Y), 250);

    do_reset();
    bus.sin = 8'h7F; bus.cos = 8'h00;
    fire_once();
    chk("up_y0", int'(bus.Bullet0Y), 250);
    tick();
    chk("up_y1", int'(bus.Bullet0Y), 243);
    tick();
    chk("up_y2", int'(bus.Bullet0Y), 236);

    do_reset();
    bus.sin = 8'hFF;
    fire_once();
    chk("down_y0", int'(bus.Bullet0Y), 250);
    tick();
    chk("down_y1", int'(bus.Bullet0Y), 257);

    do_reset();
    bus.sin = 8'h00; bus.cos = 8'h7F;
    fire_once();
    tick();
    chk("bounce_pre", int'(bus.Bullet0X), 307);
    bus.hitWallX = 2'b01;
    tick();
    chk("bounce_hit", int'(bus.Bullet0X), 300);
    bus.hitWallX = 2'b00;
    tick();
    chk("bounce_after1", int'(bus.Bullet0X), 293);
    tick();
    chk("bounce_after2", int'(bus.Bullet0X), 286);

    do_reset();
    bus.TankX = 10'd630;
    fire_once();
    chk("edge_x0", int'(bus.Bullet0X), 630);
    tick();
    chk("edge_x1", int'(bus.Bullet0X), 637);
    tick();
    chk("edge_free", int'(bus.BulletActive), 0);
    chk("edge_hold", int'(bus.Bullet0X), 637);

    // Cooldown and slot allocation with stationary bullets.
    do_reset();
    bus.sin = 8'h00; bus.cos = 8'h00; bus.TankX = 10'd100; bus.TankY = 10'd100;
    fire_once();
    ticks(4);
    fire_once();
    chk("cool_drop", int'(bus.BulletActive), 1);
    ticks(10);
    bus.TankX = 10'd200;
    fire_once();
    chk("second_slot", int'(bus.BulletActive), 3);
    chk("second_x", int'(bus.Bullet1X), 200);
    ticks(15);
    bus.TankX = 10'd50;
    fire_once();
    chk("full_drop", int'(bus.BulletActive), 3);
    chk("full_x0", int'(bus.Bullet0X), 100);

    // Lifetime of a stationary bullet, then asynchronous reset mid-flight.
    do_reset();
    fire_once();
    ticks(LIFE - 1);
    chk("life_last", int'(bus.BulletActive), 1);
    tick();
    chk("life_end", int'(bus.BulletActive), 0);
    tick();
    fire_once();
    ticks(3);
    chk("mid_active", int'(bus.BulletActive), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_rst_act", int'(bus.BulletActive), 0);
    chk("async_rst_x", int'(bus.Bullet0X), 0);
    model_reset();
    Reset = 1'b0;

    // Randomized play against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.ShootBullet = ($urandom_range(0, 2) == 0);
      bus.sin   = 8'($urandom);
      bus.cos   = 8'($urandom);
      bus.TankX = 10'($urandom_range(0, 639));
      bus.TankY = 10'($urandom_range(0, 479));
      bus.hitWallX = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      bus.hitWallY = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bullet_ctrl.md
BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 The block SHALL have parameter BULLET_STEP, default 8, meaning the speed multiplier applied to the sin/cos magnitude.
REQ-002 The block SHALL have parameter LIFETIME, default 240, meaning the number of frames a bullet flies.
REQ-003 The block SHALL have parameter COOLDOWN, default 15, meaning the number of frames after an accepted shot before another shot is accepted.
REQ-004 The block SHALL have port frame_clk, input, 1 bit: frame-rate clock.
REQ-005 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port ShootBullet, input, 1 bit: fire request level from the tank controller.
REQ-007 The block SHALL have ports TankX and TankY, input, 10 bits each: tank centre position.
REQ-008 The block SHALL have ports sin and cos, input, 8 bits each, sign-magnitude: bit7 is the sign (1 = negative), bits [6:0] are the magnitude; 127 represents 1.0.
REQ-009 The block SHALL have ports hitWallX and hitWallY, input, 2 bits each: per-slot wall contact; bit i refers to slot i.
REQ-010 The block SHALL have ports Bullet0X, Bullet0Y, Bullet1X and Bullet1Y, output, 10 bits each: bullet positions.
REQ-011 The block SHALL have port BulletActive, output, 2 bits: bit i is 1 while slot i is in FLY.
REQ-012 The block SHALL have port BulletS, output, 10 bits: bullet size, constant 2.

Function
REQ-013 All state SHALL update on the rising edge of frame_clk; all outputs SHALL be registered.
REQ-014 Each of the two slots SHALL hold a 1-bit state FREE/FLY, X and Y (10 bits each), vx and vy (10-bit two's complement), and an 8-bit age.
REQ-015 The block SHALL detect a fire request as a rising edge of ShootBullet: ShootBullet is 1 on this edge and was 0 on the previous edge (a registered copy).
REQ-016 A fire request SHALL be accepted only if cooldown is 0 and at least one slot is FREE before this edge; otherwise the request SHALL be dropped, not queued.
REQ-017 An accepted fire SHALL use the lowest-index FREE slot.
REQ-018 On the accepted-fire edge the slot SHALL enter FLY with X=TankX, Y=TankY and age=0, and cooldown SHALL load COOLDOWN; BulletActive SHALL therefore be visible one edge after the request.
REQ-019 Launch speed: sx=(BULLET_STEP*cos[6:0])>>7 and sy=(BULLET_STEP*sin[6:0])>>7, each a 14-bit product, zero-extended to 10 bits.
REQ-020 Launch direction: vx=+sx if cos[7]=0, else -sx; vy=-sy if sin[7]=0, else +sy (screen Y grows downward); a magnitude of 0 SHALL yield 0 regardless of sign.
REQ-021 When cooldown is nonzero it SHALL decrement by 1 each edge; it SHALL saturate at 0.
REQ-022 For each FLY slot on edges after launch, the order SHALL be:
  - if hitWallX[i]=1, vx is negated;
  - if hitWallY[i]=1, vy is negated;
  - both flags set negates both;
  - then the next position is computed with the updated velocity.
REQ-023 hitWallX/hitWallY SHALL be ignored for FREE slots and on the launch edge.
REQ-024 The next position SHALL be computed as 11-bit signed X+vx and Y+vy.
REQ-025 If the next X is outside 0..639 or the next Y is outside 0..479, the slot SHALL go FREE and its position SHALL hold; otherwise the position SHALL update and age SHALL increment.
REQ-026 A slot SHALL go FREE on the edge where age=LIFETIME-1 before the increment, with no move applied on that edge, so it is active for exactly LIFETIME edges after launch.
REQ-027 A slot that frees on edge k SHALL NOT be reusable until edge k+1; a fire request on edge k SHALL see it as busy.
REQ-028 A FREE slot SHALL hold its last X/Y values; consumers SHALL gate on BulletActive.

Reset
REQ-029 Reset SHALL be asynchronous and immediate, including in the middle of a flight.
REQ-030 On reset:
  - both slots go FREE;
  - BulletActive=2'b00;
  - all positions, velocities, ages and cooldown = 0;
  - the ShootBullet history register = 0.
REQ-031 After reset is released, ShootBullet already high on the first edge SHALL count as a rising edge.

Verification
REQ-032 The bench SHALL cover: cos=8'h7F, sin=8'h00, TankX=300, TankY=250, ShootBullet pulse -> next edge slot0 at (300,250) with BulletActive=01; following edge (307,250).
REQ-033 The bench SHALL cover: sin=8'h7F, cos=8'h00 fire -> Y goes 250, then 243, then 236; with sin=8'hFF instead -> Y goes 250, then 257.
REQ-034 The bench SHALL cover: slot0 flying with vx=+7, hitWallX=01 for one edge -> X decreases by 7 on that edge and every edge after.
REQ-035 The bench SHALL cover: launch at X=630 with vx=+7 -> X goes 630, then 637; the next edge frees the slot with X held at 637.
REQ-036 The bench SHALL cover: ShootBullet rising edges 5 edges apart -> second shot dropped; rising edges 16 apart -> second shot goes to slot1 with BulletActive=11; a third rising edge 16 after that, with both slots busy -> dropped.
REQ-037 The bench SHALL cover: a stationary bullet (sin=cos=0) -> BulletActive bit clears exactly 240 edges after launch; Reset asserted during flight -> BulletActive=00 immediately, without waiting for a clock edge.
